// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM states, oversampling constants).
// Used by the receiver today and intended for the transmitter later.
package uart_pkg;

  localparam int unsigned OS_RATE   = 16;           // ticks per bit
  localparam int unsigned OS_MID    = 7;            // tick index of mid start bit
  localparam int unsigned OS_LAST   = OS_RATE - 1;  // last tick of a bit period
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned OS_W      = 4;            // os_cnt width
  localparam int unsigned BIT_W     = 3;            // bit_cnt width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: DDFS phase accumulator; the carry out of acc+K is a
// single-cycle tick enable at f_clk*K/2^N.
// Ports: clk, rst_n (async active-low), tick_o (one-cycle enable).
module uart_baud_tick #(
  parameter int unsigned K = 1,
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  logic [N-1:0] acc_q;
  logic [N:0]   sum_c;

  // Extra MSB captures the carry out of the accumulator add.
  assign sum_c = {1'b0, acc_q} + (N+1)'(K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_o <= 1'b0;
    end else begin
      acc_q  <= sum_c[N-1:0];
      tick_o <= sum_c[N];
    end
  end

endmodule

// File: rtl/uart_rx_ddfs.sv
// uart_rx_ddfs: 8N1 UART receiver, 16x oversampled from a DDFS tick,
// delivering bytes over valid/ready.
// Ports: clk, rst_n (async active-low), rx_i (serial line, idle high),
//   data_o/valid_o/ready_i (byte handshake), frame_err_o and overrun_o
//   (one-cycle pulses), busy_o (receiver not idle).
module uart_rx_ddfs
  import uart_pkg::*;
#(
  parameter int unsigned K = 1,
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  logic tick;

  uart_baud_tick #(.K(K), .N(N)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // Two-flop synchroniser, reset to idle-high so reset never looks like a start bit.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  uart_state_e          state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 byte_done;

  // Next-state: FSM steps only on tick; handshake evaluated every cycle.
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d  = ST_START;
            os_cnt_d = '0;
          end
        end
        ST_START: begin
          if (os_cnt_q == OS_W'(OS_MID)) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            // A line that is high again at mid start bit was a glitch.
            state_d   = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            os_cnt_d = OS_W'(os_cnt_q + OS_W'(1));
          end
        end
        ST_DATA: begin
          if (os_cnt_q == OS_W'(OS_LAST)) begin
            os_cnt_d = '0;
            shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = BIT_W'(bit_cnt_q + BIT_W'(1));
            end
          end else begin
            os_cnt_d = OS_W'(os_cnt_q + OS_W'(1));
          end
        end
        ST_STOP: begin
          if (os_cnt_q == OS_W'(OS_LAST)) begin
            os_cnt_d = '0;
            if (rx_s_q) begin
              byte_done = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            os_cnt_d = OS_W'(os_cnt_q + OS_W'(1));
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a held-low line can't re-trigger.
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Completed byte loads only if the output slot is free or being drained.
    if (byte_done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_ddfs.sv
// tb_uart_rx_ddfs: directed bench for uart_rx_ddfs with K=1, N=4
// (tick every 16 clk, one bit = 256 clk).
module tb_uart_rx_ddfs;

  localparam int unsigned BIT_CYC = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Monitor state, sampled on the falling edge.
  logic [7:0] rxq[$];
  int n_ferr = 0;
  int n_ovr = 0;
  int valid_run = 0;
  int max_valid_run = 0;

  uart_rx_ddfs #(.K(1), .N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && ready) rxq.push_back(data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (valid) valid_run++;
    else valid_run = 0;
    if (valid_run > max_valid_run) max_valid_run = valid_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, leaving the bench 2 ns after the rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  int q0;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    wait_cyc(4);

    // Reset state
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_cyc(40);

    // Single byte 0xA5, ready high
    max_valid_run = 0;
    send_byte(8'hA5, 1'b1);
    wait_cyc(32);
    check("a5_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() >= 1) check("a5_data", 32'(rxq[0]), 32'hA5);
    check("a5_ferr", 32'(n_ferr), 32'd0);
    check("a5_vpulse", 32'(max_valid_run), 32'd1);
    check("a5_vlow", 32'(valid), 32'd0);

    // Start-bit glitch: low for 3 ticks
    rx = 1'b0;
    wait_cyc(40);
    check("gl_busy_hi", 32'(busy), 32'd1);
    wait_cyc(8);
    rx = 1'b1;
    wait_cyc(200);
    check("gl_busy_lo", 32'(busy), 32'd0);
    check("gl_count", 32'(rxq.size()), 32'd1);

    // Framing error with line held low, then recovery
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b0 | ((8'h3C >> i) & 1));
    rx = 1'b0;
    wait_cyc(10 * BIT_CYC);
    check("fe_ferr", 32'(n_ferr), 32'd1);
    check("fe_busy", 32'(busy), 32'd1);
    wait_cyc(10 * BIT_CYC);
    rx = 1'b1;
    wait_cyc(40);
    check("fe_busy_lo", 32'(busy), 32'd0);
    check("fe_ferr_once", 32'(n_ferr), 32'd1);
    check("fe_novalid", 32'(rxq.size()), 32'd1);
    wait_cyc(BIT_CYC);
    send_byte(8'h5A, 1'b1);
    wait_cyc(32);
    check("5a_count", 32'(rxq.size()), 32'd2);
    if (rxq.size() >= 2) check("5a_data", 32'(rxq[1]), 32'h5A);

    // Overrun: consumer stalled across two frames
    ready = 1'b0;
    send_byte(8'h11, 1'b1);
    wait_cyc(32);
    check("ov_valid1", 32'(valid), 32'd1);
    check("ov_data1", 32'(data), 32'h11);
    send_byte(8'h22, 1'b1);
    wait_cyc(32);
    check("ov_pulse", 32'(n_ovr), 32'd1);
    check("ov_data_keep", 32'(data), 32'h11);
    check("ov_valid2", 32'(valid), 32'd1);
    ready = 1'b1;
    wait_cyc(1);
    check("ov_vdrop", 32'(valid), 32'd0);
    check("ov_count", 32'(rxq.size()), 32'd3);
    if (rxq.size() >= 3) check("ov_hs_data", 32'(rxq[2]), 32'h11);

    // Back-to-back frames, no idle gap
    wait_cyc(BIT_CYC);
    max_valid_run = 0;
    q0 = rxq.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    wait_cyc(32);
    check("bb_count", 32'(rxq.size() - q0), 32'd3);
    if (rxq.size() >= q0 + 3) begin
      check("bb_d0", 32'(rxq[q0]), 32'h00);
      check("bb_d1", 32'(rxq[q0+1]), 32'hFF);
      check("bb_d2", 32'(rxq[q0+2]), 32'h81);
    end
    check("bb_ferr", 32'(n_ferr), 32'd1);
    check("bb_ovr", 32'(n_ovr), 32'd1);
    check("bb_vpulse", 32'(max_valid_run), 32'd1);
    check("bb_last", 32'(data), 32'h81);

    // Reset mid-frame of 0x77, then receive 0xC3
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mr_data", 32'(data), 32'h0);
    check("mr_valid", 32'(valid), 32'h0);
    check("mr_ferr", 32'(frame_err), 32'h0);
    check("mr_ovr", 32'(overrun), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    q0 = rxq.size();
    send_byte(8'hC3, 1'b1);
    wait_cyc(32);
    check("c3_count", 32'(rxq.size() - q0), 32'd1);
    check("c3_data", 32'(data), 32'hC3);
    check("c3_ferr", 32'(n_ferr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
